// File: rtl/cpu_common.sv
// cpu_common: shared CPU enums and constants for the fetch path
package cpu_common;
  typedef enum logic [1:0] {
    FETCH_NOP     = 2'd0,
    FETCH_INC_PC  = 2'd1,
    FETCH_LOAD_PC = 2'd2
  } fetch_operation_t;
  typedef enum logic [1:0] {REQ0, RD0, RD1, DONE} fetch_state_t;
  localparam int LONG_BIT_DEFAULT = 15;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches 1- or 2-word instructions and holds them for decode
module fetch_unit
  import cpu_common::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int LONG_BIT = LONG_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_async,
  input  fetch_operation_t  fetch_operation,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              fetch_complete,
  output logic [DATA_W-1:0] inst_word0,
  output logic [DATA_W-1:0] inst_word1,
  output logic              inst_long,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [DATA_W-1:0] imem_rdata
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] w0_q, w0_d, w1_q, w1_d;
  logic long_q, long_d;
  logic rd_long;
  assign rd_long = imem_rdata[LONG_BIT];
  assign pc_next = pc_q + (long_q ? ADDR_W'(2) : ADDR_W'(1));
  assign pc = pc_q;
  assign inst_word0 = w0_q;
  assign inst_word1 = w1_q;
  assign inst_long = long_q;
  assign fetch_complete = state_q == DONE;
  // memory strobes are combinational from state, so they are forced quiet while reset is held
  assign imem_rd_en = !rst_async && (state_q == REQ0 || (state_q == RD0 && rd_long));
  assign imem_addr = rst_async ? '0 : (state_q == RD0 ? pc_q + ADDR_W'(1) : pc_q);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    w0_d = w0_q;
    w1_d = w1_q;
    long_d = long_q;
    case (state_q)
      REQ0: state_d = RD0;
      RD0: begin
        w0_d = imem_rdata;
        long_d = rd_long;
        state_d = rd_long ? RD1 : DONE;
      end
      RD1: begin
        w1_d = imem_rdata;
        state_d = DONE;
      end
      DONE: begin
        pc_d = fetch_operation == FETCH_INC_PC ? pc_next :
               fetch_operation == FETCH_LOAD_PC ? pc_load_value : pc_q;
        state_d = fetch_operation inside {FETCH_INC_PC, FETCH_LOAD_PC} ? REQ0 : DONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= REQ0;
      pc_q <= RESET_PC;
      w0_q <= '0;
      w1_q <= '0;
      long_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
      long_q <= long_d;
    end
  end
  a_cmd_only_in_done: assert property (@(posedge clk) disable iff (rst_async)
    state_q != DONE |-> !(fetch_operation inside {FETCH_INC_PC, FETCH_LOAD_PC}))
    else $warning("fetch command ignored outside DONE");
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a transaction-level fetch model
module tb_fetch_unit;
  import cpu_common::*;
  logic clk = 0;
  logic rst_async = 0;
  fetch_operation_t fetch_operation = FETCH_NOP;
  logic [12:0] pc_load_value = '0;
  logic fetch_complete, inst_long, imem_rd_en;
  logic [15:0] inst_word0, inst_word1, imem_rdata;
  logic [12:0] pc, pc_next, imem_addr;
  logic [15:0] mem [8192];
  int checks = 0;
  int errors = 0;
  int n;
  fetch_unit dut (
    .clk(clk), .rst_async(rst_async), .fetch_operation(fetch_operation),
    .pc_load_value(pc_load_value), .fetch_complete(fetch_complete),
    .inst_word0(inst_word0), .inst_word1(inst_word1), .inst_long(inst_long),
    .pc(pc), .pc_next(pc_next), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];
  logic [12:0] m_pc, m_pc1, m_pcn;
  logic [15:0] m_w1;
  int m_age;
  logic m_long, m_done;
  assign m_long = mem[m_pc][15];
  assign m_pc1 = m_pc + 13'd1;
  assign m_pcn = m_pc + (m_long ? 13'd2 : 13'd1);
  assign m_done = m_age >= (m_long ? 3 : 2);
  always @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      m_pc <= '0;
      m_age <= 0;
      m_w1 <= '0;
    end else if (m_done && fetch_operation inside {FETCH_INC_PC, FETCH_LOAD_PC}) begin
      m_pc <= fetch_operation == FETCH_INC_PC ? m_pcn : pc_load_value;
      m_age <= 0;
      if (m_long) m_w1 <= mem[m_pc1];
    end else if (!m_done) m_age <= m_age + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_async) begin
      chk("rst_complete", fetch_complete, 0);
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_word0", inst_word0, 0);
      chk("rst_word1", inst_word1, 0);
      chk("rst_long", inst_long, 0);
      chk("rst_pc", pc, 0);
    end else begin
      chk("m_pc", pc, m_pc);
      chk("m_complete", fetch_complete, m_done);
      if (m_done) begin
        chk("m_word0", inst_word0, mem[m_pc]);
        chk("m_long", inst_long, m_long);
        chk("m_word1", inst_word1, m_long ? mem[m_pc1] : m_w1);
        chk("m_pc_next", pc_next, m_pcn);
        chk("m_rd_en_done", imem_rd_en, 0);
      end else begin
        chk("m_rd_en", imem_rd_en, m_age == 0 || (m_age == 1 && m_long));
        if (m_age == 0 || (m_age == 1 && m_long)) chk("m_addr", imem_addr, m_age == 0 ? m_pc : m_pc1);
      end
    end
  end
  task automatic do_cmd(input fetch_operation_t op, input logic [12:0] v);
    @(posedge clk) #1;
    fetch_operation = op;
    pc_load_value = v;
    @(posedge clk) #1;
    fetch_operation = FETCH_NOP;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fetch_complete && cyc < 20);
    chk("done_timeout", fetch_complete, 1);
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i) & 16'h7FFF;
    mem[0] = 16'h0123;
    mem[1] = 16'h8004;
    mem[2] = 16'hBEEF;
    mem[3] = 16'h8111;
    mem[4] = 16'h2222;
    mem[13'h100] = 16'h0042;
    mem[13'h101] = 16'h0007;
    mem[13'h1FFF] = 16'h8ABC;
    rst_async = 1;
    repeat (2) @(posedge clk);
    #1 rst_async = 0;
    @(negedge clk);
    chk("c1_addr", imem_addr, 0);
    chk("c1_rd_en", imem_rd_en, 1);
    wait_done(n);
    chk("a_lat", n, 2);
    chk("a_word0", inst_word0, 16'h0123);
    chk("a_long", inst_long, 0);
    chk("a_pc", pc, 0);
    chk("a_pc_next", pc_next, 1);
    do_cmd(FETCH_INC_PC, 0);
    wait_done(n);
    chk("b_lat", n, 4);
    chk("b_word0", inst_word0, 16'h8004);
    chk("b_word1", inst_word1, 16'hBEEF);
    chk("b_long", inst_long, 1);
    chk("b_pc", pc, 1);
    chk("b_pc_next", pc_next, 3);
    do_cmd(FETCH_LOAD_PC, 13'h0100);
    @(negedge clk);
    chk("c_drop", fetch_complete, 0);
    chk("c_addr", imem_addr, 13'h0100);
    wait_done(n);
    chk("c_lat", n, 2);
    chk("c_word0", inst_word0, 16'h0042);
    chk("c_pc", pc, 13'h0100);
    chk("c_stale_word1", inst_word1, 16'hBEEF);
    repeat (10) begin
      @(negedge clk);
      chk("d_hold_complete", fetch_complete, 1);
      chk("d_hold_rd_en", imem_rd_en, 0);
      chk("d_hold_word0", inst_word0, 16'h0042);
    end
    @(posedge clk) #1;
    fetch_operation = fetch_operation_t'(2'b11);
    @(posedge clk) #1;
    fetch_operation = FETCH_NOP;
    @(negedge clk);
    chk("d_bad_op_complete", fetch_complete, 1);
    chk("d_bad_op_pc", pc, 13'h0100);
    do_cmd(FETCH_INC_PC, 0);
    @(posedge clk) #1;
    fetch_operation = FETCH_INC_PC;
    @(posedge clk) #1;
    fetch_operation = FETCH_NOP;
    wait_done(n);
    chk("e_pc", pc, 13'h0101);
    chk("e_word0", inst_word0, 16'h0007);
    do_cmd(FETCH_LOAD_PC, 13'h1FFF);
    @(negedge clk);
    @(negedge clk);
    chk("f_wrap_addr", imem_addr, 0);
    chk("f_wrap_rd_en", imem_rd_en, 1);
    wait_done(n);
    chk("f_lat", n, 2);
    chk("f_word0", inst_word0, 16'h8ABC);
    chk("f_word1", inst_word1, 16'h0123);
    chk("f_pc", pc, 13'h1FFF);
    chk("f_pc_next", pc_next, 13'h0001);
    do_cmd(FETCH_INC_PC, 0);
    wait_done(n);
    chk("g_pc", pc, 13'h0001);
    chk("g_word0", inst_word0, 16'h8004);
    do_cmd(FETCH_INC_PC, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_async = 1;
    #1;
    chk("h_complete", fetch_complete, 0);
    chk("h_rd_en", imem_rd_en, 0);
    chk("h_word0", inst_word0, 0);
    chk("h_long", inst_long, 0);
    chk("h_pc", pc, 0);
    #4 rst_async = 0;
    wait_done(n);
    chk("h_lat", n, 2);
    chk("h_word0_after", inst_word0, 16'h0123);
    chk("h_pc_after", pc, 0);
    chk("h_word1_after", inst_word1, 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch unit. It is the responder to the control FSM's fetch_operation / fetch_complete handshake.
- Owns the PC and reads 1- or 2-word instructions from synchronous instruction memory.
- Holds the fetched words stable for decode.
- Sits between control and decode on the CPU side, and the instruction memory port on the other side.

Parameters:
- ADDR_W, 13, instruction-memory word-address width (PC width).
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- LONG_BIT, 15, bit of word 0 that, when 1, marks a two-word instruction.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_async  in  1  reset, asynchronous, active-high.
- fetch_operation  in  fetch_operation_t  command from control: FETCH_NOP, FETCH_INC_PC or FETCH_LOAD_PC.
- pc_load_value  in  ADDR_W  target PC, sampled with FETCH_LOAD_PC.
- fetch_complete  out  1  level; instruction words valid and stable.
- inst_word0  out  DATA_W  first instruction word.
- inst_word1  out  DATA_W  second word; valid only when inst_long=1.
- inst_long  out  1  fetched instruction is two words.
- pc  out  ADDR_W  address of the current instruction.
- pc_next  out  ADDR_W  pc + (inst_long ? 2 : 1) mod 2^ADDR_W; the return address for calls.
- imem_addr  out  ADDR_W  instruction-memory read address.
- imem_rd_en  out  1  read strobe.
- imem_rdata  in  DATA_W  read data, valid one cycle after the edge that samples imem_addr/imem_rd_en.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_async is asynchronous and active-high.
- Reset values:
  - state=REQ0, pc=RESET_PC
  - fetch_complete=0, inst_word0=0, inst_word1=0, inst_long=0
  - imem_rd_en=0, imem_addr=0
- A fetch starts automatically on the first cycle after reset deassertion.
- States: REQ0, RD0, RD1, DONE.
- REQ0:
  - Drive imem_addr=pc, imem_rd_en=1.
  - Next state: RD0.
- RD0:
  - Capture imem_rdata into inst_word0.
  - inst_long <= imem_rdata[LONG_BIT].
  - If long: drive imem_addr=pc+1 (wraps mod 2^ADDR_W), imem_rd_en=1, next state RD1.
  - Else: next state DONE.
- RD1:
  - Capture imem_rdata into inst_word1.
  - Next state: DONE.
- DONE:
  - fetch_complete=1 (combinational from state). Outputs and pc are held.
  - FETCH_NOP: stay in DONE.
  - FETCH_INC_PC: pc <= pc_next, next state REQ0.
  - FETCH_LOAD_PC: pc <= pc_load_value, next state REQ0.
  - fetch_complete drops in the cycle after the command edge.
- Latency, counted from entry to REQ0:
  - single-word instruction: fetch_complete high 2 cycles later;
  - two-word instruction: 3 cycles later.
- imem_rd_en=0 in DONE and RD1.
- Commands other than FETCH_NOP received in REQ0/RD0/RD1 are ignored. This is a protocol violation; flag it with a simulation-only assertion.
- inst_word1 is not cleared on a short fetch and keeps its stale value. Consumers gate it with inst_long.
- PC arithmetic is unsigned ADDR_W bits with silent wrap, e.g. pc=2^ADDR_W-1, long -> pc_next=1.
- Reset asserted mid-fetch aborts immediately. Any in-flight memory data is discarded. The fetch restarts from RESET_PC after reset release.
- A fetch_operation encoding outside the enum is treated as FETCH_NOP.

Decomposition:
- cpu_common package:
  - fetch_operation_t with FETCH_NOP, FETCH_INC_PC and new member FETCH_LOAD_PC, appended so existing encodings are unchanged.
  - fetch_state_t enum {REQ0, RD0, RD1, DONE}.
  - Default LONG_BIT constant.
- Single module; no sub-module is warranted. The PC register, next-PC adder and FSM are all small.

Test Plan:
- Reset then release with mem[0]=16'h0123 (short):
  - imem_addr=0 with rd_en in cycle 1;
  - fetch_complete=1 in cycle 3, inst_word0=16'h0123, inst_long=0, pc=0, pc_next=1.
- mem[1]=16'h8004, mem[2]=16'hBEEF, issue FETCH_INC_PC from pc=0:
  - reads addresses 1 then 2;
  - complete with inst_word0=16'h8004, inst_word1=16'hBEEF, inst_long=1, pc=1, pc_next=3.
- In DONE, issue FETCH_LOAD_PC with pc_load_value=13'h0100, mem[0x100]=16'h0042:
  - fetch_complete drops next cycle, imem_addr=0x100;
  - complete with inst_word0=16'h0042, pc=0x100.
- Hold FETCH_NOP for 10 cycles in DONE:
  - fetch_complete stays 1, imem_rd_en=0, all outputs unchanged;
  - FETCH_INC_PC driven during RD0 is ignored and pc is unchanged.
- Wrap cases:
  - pc=0x1FFF with a long instruction: second read at address 0, pc_next=0x0001;
  - INC_PC then fetches from 0x0001.
- Assert rst_async during RD1 for a non-edge-aligned half cycle:
  - outputs reset immediately, fetch_complete=0;
  - after release the fetch restarts at RESET_PC=0 and completes with mem[0].
